// File: rtl/toggle_cover_scheduler_if.sv
// Valid/ready index stream between the toggle-cover scheduler and its coverage sink.
// The master drives the beat and the slave drives the acceptance.
interface toggle_cover_scheduler_if;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_index;

    modport master (output out_valid, output out_index, input out_ready);
    modport slave  (input out_valid, input out_index, output out_ready);
endinterface

// File: rtl/toggle_cover_scheduler.sv
// Reports each toggle cover point once per epoch as a valid/ready stream of global indices.
// A software clear starts a new epoch, so every point becomes reportable again.
module toggle_cover_scheduler #(
    parameter int WIDTH       = 62,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 9715
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             hit,
    input  logic                         clear,
    toggle_cover_scheduler_if.master     out,
    output logic [$clog2(WIDTH+1)-1:0]   emit_count,
    output logic                         all_covered
);

    localparam int             CW        = $clog2(WIDTH + 1);
    localparam int             BW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  COUNT_MAX = CW'(WIDTH);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] seen_q, seen_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             out_valid_q, out_valid_d;
    logic [63:0]      out_index_q, out_index_d;
    logic [BW-1:0]    out_bit_q, out_bit_d;
    logic [CW-1:0]    emit_count_q, emit_count_d;
    logic             all_covered_q, all_covered_d;

    logic [WIDTH-1:0] hit_v;
    logic [WIDTH-1:0] new_bits;
    logic [BW-1:0]    next_bit;
    logic             accept;
    logic             load;

    function automatic logic [BW-1:0] lowest_bit(input logic [WIDTH-1:0] v);
        lowest_bit = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) lowest_bit = BW'(i);
        end
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        hit_v         = $isunknown(hit) ? '0 : hit;
        new_bits      = hit_v & ~seen_q;
        accept        = out_valid_q & out.out_ready;
        next_bit      = lowest_bit(pend_q);
        // The load source is the registered pend, so bits captured this edge wait one cycle.
        load          = (pend_q != '0) && ((state_q == IDLE) || accept);

        state_d       = state_q;
        seen_d        = seen_q | new_bits;
        pend_d        = pend_q | new_bits;
        out_valid_d   = out_valid_q;
        out_index_d   = out_index_q;
        out_bit_d     = out_bit_q;
        emit_count_d  = emit_count_q;
        all_covered_d = &seen_q;

        if (accept && emit_count_q != COUNT_MAX) begin
            emit_count_d = emit_count_q + 1'b1;
        end

        if (clear) begin
            // The beat in flight survives into the new epoch and counts there.
            seen_d        = hit_v;
            pend_d        = hit_v;
            all_covered_d = 1'b0;
            emit_count_d  = accept ? CW'(1) : '0;
            if (out_valid_q) begin
                seen_d[out_bit_q] = 1'b1;
                pend_d[out_bit_q] = 1'b0;
            end
            if (accept) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        end else if (load) begin
            pend_d[next_bit] = 1'b0;
            state_d          = PRESENT;
            out_valid_d      = 1'b1;
            out_bit_d        = next_bit;
            out_index_d      = 64'(COVER_INDEX) + 64'(next_bit);
        end else if (accept) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: seen/pend are flop vectors, not RAM, and must clear so an epoch starts empty.
            state_q       <= IDLE;
            seen_q        <= '0;
            pend_q        <= '0;
            out_valid_q   <= 1'b0;
            out_index_q   <= '0;
            out_bit_q     <= '0;
            emit_count_q  <= '0;
            all_covered_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            seen_q        <= seen_d;
            pend_q        <= pend_d;
            out_valid_q   <= out_valid_d;
            out_index_q   <= out_index_d;
            out_bit_q     <= out_bit_d;
            emit_count_q  <= emit_count_d;
            all_covered_q <= all_covered_d;
        end
    end

    assign out.out_valid = out_valid_q;
    assign out.out_index = out_index_q;
    assign emit_count    = emit_count_q;
    assign all_covered   = all_covered_q;

    a_index_range : assert property (@(posedge clock) disable iff (!reset)
        out_valid_q |-> (out_index_q < 64'(COVER_TOTAL)));

    a_hold_stable : assert property (@(posedge clock) disable iff (!reset)
        (out_valid_q && !out.out_ready) |=> (out_valid_q && $stable(out_index_q)));

    a_count_bound : assert property (@(posedge clock) disable iff (!reset)
        emit_count_q <= COUNT_MAX);

endmodule

// File: tb/tb_toggle_cover_scheduler.sv
// Directed bench for toggle_cover_scheduler: a set-based reference model checked every cycle,
// plus literal beat lists and output values for each scenario.
module tb_toggle_cover_scheduler;

    localparam int W  = 62;
    localparam int CI = 100;
    localparam int CW = $clog2(W + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  hit   = '1;
    logic          clear = 1'b0;
    logic [CW-1:0] emit_count;
    logic          all_covered;

    toggle_cover_scheduler_if bus ();

    toggle_cover_scheduler #(
        .WIDTH       (W),
        .COVER_INDEX (CI),
        .COVER_TOTAL (9715)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .hit         (hit),
        .clear       (clear),
        .out         (bus.master),
        .emit_count  (emit_count),
        .all_covered (all_covered)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 1'b0;

    // Reference model: sets of seen/pending points and the point currently offered.
    bit   m_seen [W];
    bit   m_pend [W];
    bit   m_busy  = 1'b0;
    int   m_bit   = 0;
    int   m_index = 0;
    int   m_count = 0;
    bit   m_ac    = 1'b0;
    int   m_beats[$];
    int   dut_beats[$];
    int   exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_beats(input string name, input int exp[$]);
        check({name, " dut beat count"}, 64'(dut_beats.size()), 64'(exp.size()));
        check({name, " model beat count"}, 64'(m_beats.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < dut_beats.size()) check({name, " dut beat"}, 64'(dut_beats[i]), 64'(exp[i]));
            if (i < m_beats.size())   check({name, " model beat"}, 64'(m_beats[i]), 64'(exp[i]));
        end
    endtask

    always @(posedge clock) begin
        bit accepted;
        bit was_all;
        int nxt;
        started = 1'b1;
        if (!reset) begin
            foreach (m_seen[i]) begin
                m_seen[i] = 1'b0;
                m_pend[i] = 1'b0;
            end
            m_busy  = 1'b0;
            m_index = 0;
            m_count = 0;
            m_ac    = 1'b0;
        end else begin
            accepted = m_busy && bus.out_ready;
            was_all  = 1'b1;
            foreach (m_seen[i]) if (!m_seen[i]) was_all = 1'b0;
            if (accepted) m_beats.push_back(m_index);
            if (clear) begin
                foreach (m_seen[i]) begin
                    m_seen[i] = hit[i];
                    m_pend[i] = hit[i];
                end
                if (m_busy) begin
                    m_seen[m_bit] = 1'b1;
                    m_pend[m_bit] = 1'b0;
                end
                m_count = accepted ? 1 : 0;
                if (accepted) m_busy = 1'b0;
                m_ac = 1'b0;
            end else begin
                nxt = -1;
                for (int i = W - 1; i >= 0; i--) if (m_pend[i]) nxt = i;
                foreach (m_seen[i]) begin
                    if (hit[i] && !m_seen[i]) begin
                        m_seen[i] = 1'b1;
                        m_pend[i] = 1'b1;
                    end
                end
                if (accepted && m_count < W) m_count++;
                if ((!m_busy || accepted) && nxt >= 0) begin
                    m_busy        = 1'b1;
                    m_bit         = nxt;
                    m_index       = CI + nxt;
                    m_pend[nxt]   = 1'b0;
                end else if (accepted) begin
                    m_busy = 1'b0;
                end
                m_ac = was_all;
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            check("out_valid", 64'(bus.out_valid), 64'(m_busy));
            check("out_index", bus.out_index, 64'(m_index));
            check("emit_count", 64'(emit_count), 64'(m_count));
            check("all_covered", 64'(all_covered), 64'(m_ac));
            if (reset && bus.out_valid && bus.out_ready) dut_beats.push_back(int'(bus.out_index));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic new_scenario();
        dut_beats.delete();
        m_beats.delete();
    endtask

    initial begin
        bus.out_ready = 1'b1;

        // 1: reset held with all hits asserted captures nothing.
        tick(3);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset emit_count", 64'(emit_count), 64'd0);
        check("reset all_covered", 64'(all_covered), 64'd0);
        reset = 1'b1;
        hit   = '0;
        tick(3);
        check("post-reset idle", 64'(bus.out_valid), 64'd0);

        // 2: two points in one cycle, then a repeat hit.
        new_scenario();
        hit = W'(64'h9);
        tick(1);
        hit = '0;
        tick(4);
        exp_q = '{100, 103};
        check_beats("pair", exp_q);
        check("pair emit_count", 64'(emit_count), 64'd2);
        hit = W'(64'h8);
        tick(1);
        hit = '0;
        tick(3);
        check_beats("rehit", exp_q);

        // 3: stall with a second point arriving mid-stall.
        new_scenario();
        bus.out_ready = 1'b0;
        hit = W'(64'h20);
        tick(1);
        hit = W'(64'h4);
        tick(1);
        hit = '0;
        for (int i = 0; i < 6; i++) begin
            check("stall valid", 64'(bus.out_valid), 64'd1);
            check("stall index", bus.out_index, 64'd105);
            tick(1);
        end
        bus.out_ready = 1'b1;
        tick(3);
        exp_q = '{105, 102};
        check_beats("stall", exp_q);
        check("stall emit_count", 64'(emit_count), 64'd4);

        // 4: clear while a beat is held.
        new_scenario();
        bus.out_ready = 1'b0;
        hit = W'(64'h80);
        tick(1);
        hit = '0;
        tick(1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear held index", bus.out_index, 64'd107);
        check("clear emit_count", 64'(emit_count), 64'd0);
        bus.out_ready = 1'b1;
        tick(2);
        check("clear kept beat count", 64'(emit_count), 64'd1);
        hit = W'(64'h80);
        tick(1);
        hit = '0;
        tick(3);
        exp_q = '{107};
        check_beats("clear", exp_q);
        hit = W'(64'h200);
        tick(1);
        hit = '0;
        tick(3);
        exp_q = '{107, 109};
        check_beats("after clear", exp_q);
        check("after clear emit_count", 64'(emit_count), 64'd2);

        // 5: every point at once after a fresh epoch.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        new_scenario();
        hit = '1;
        tick(1);
        hit = '0;
        tick(66);
        exp_q.delete();
        for (int i = 0; i < W; i++) exp_q.push_back(CI + i);
        check_beats("all", exp_q);
        check("all emit_count", 64'(emit_count), 64'd62);
        check("all covered", 64'(all_covered), 64'd1);

        // 6: reset mid-stream, then replay.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        new_scenario();
        hit = '1;
        tick(1);
        hit = '0;
        for (int i = 0; i < 40 && dut_beats.size() < 10; i++) tick(1);
        check("mid-stream beats before reset", 64'(dut_beats.size()), 64'd10);
        reset = 1'b0;
        tick(1);
        check("mid reset out_valid", 64'(bus.out_valid), 64'd0);
        check("mid reset emit_count", 64'(emit_count), 64'd0);
        reset = 1'b1;
        tick(2);
        check("mid reset stays idle", 64'(bus.out_valid), 64'd0);
        new_scenario();
        hit = '1;
        tick(1);
        hit = '0;
        tick(66);
        check_beats("replay", exp_q);
        check("replay emit_count", 64'(emit_count), 64'd62);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
